// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// KEY_MAP is indexed [column][row] and gives the hex code printed on that key.
package keypad_pkg;

  localparam int COL_W = 4;
  localparam int ROW_W = 4;

  typedef struct packed {
    logic       valid;
    logic       multi;
    logic [3:0] code;
  } scan_res_t;

  localparam scan_res_t NONE = '{valid: 1'b0, multi: 1'b0, code: 4'h0};

  localparam logic [3:0] KEY_MAP [COL_W][ROW_W] = '{
    '{4'h1, 4'h4, 4'h7, 4'h0},
    '{4'h2, 4'h5, 4'h8, 4'hF},
    '{4'h3, 4'h6, 4'h9, 4'hE},
    '{4'hA, 4'hB, 4'hC, 4'hD}
  };

endpackage

// File: rtl/keypad_debounce.sv
// Accepts a new keypad state after DEBOUNCE_SCANS identical consecutive scan results.
// Also remembers the code of the last accepted key.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scan_end_i,
  input  scan_res_t  result_i,
  output scan_res_t  state_o,
  output logic       change_o,
  output logic [3:0] last_key_o
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  scan_res_t   prev_q, prev_d;
  scan_res_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        change_q, change_d;
  logic [3:0]  last_key_q, last_key_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q     <= NONE;
      state_q    <= NONE;
      cnt_q      <= '0;
      change_q   <= 1'b0;
      last_key_q <= 4'hF;
    end else begin
      prev_q     <= prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      change_q   <= change_d;
      last_key_q <= last_key_d;
    end
  end

  always_comb begin
    prev_d     = prev_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    change_d   = 1'b0;
    last_key_d = last_key_q;
    if (scan_end_i) begin
      if (result_i == prev_q)
        cnt_d = (cnt_q == CW'(DEBOUNCE_SCANS)) ? cnt_q : cnt_q + CW'(1);
      else
        cnt_d = CW'(1);
      prev_d = result_i;
      if (cnt_d == CW'(DEBOUNCE_SCANS) && result_i != state_q) begin
        state_d  = result_i;
        change_d = 1'b1;
        if (result_i.valid)
          last_key_d = result_i.code;
      end
    end
  end

  assign state_o    = state_q;
  assign change_o   = change_q;
  assign last_key_o = last_key_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad reader: row synchronizer, column dwell counter and
// per-scan accumulator; debouncing is delegated to keypad_debounce.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [3:0]       DispVal,
  output logic             key_valid,
  output logic             key_down
);

  localparam int DW = $clog2(SCAN_CYCLES);

  logic [ROW_W-1:0] sync1_q, sync2_q;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [COL_W-1:0] col_q, col_d;
  scan_res_t        acc_q, acc_d, sample_acc, scan_res, db_state;
  logic             sample, scan_end, db_change;
  logic [2:0]       n_low;
  logic [1:0]       row_hit;
  logic [3:0]       db_last_key;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      dwell_q   <= '0;
      col_idx_q <= '0;
      col_q     <= 4'b1110;
      acc_q     <= NONE;
    end else begin
      sync1_q   <= row;
      sync2_q   <= sync1_q;
      dwell_q   <= dwell_d;
      col_idx_q <= col_idx_d;
      col_q     <= col_d;
      acc_q     <= acc_d;
    end
  end

  always_comb begin
    sample    = (dwell_q == DW'(SCAN_CYCLES - 1));
    scan_end  = sample && (col_idx_q == 2'd3);
    dwell_d   = sample ? '0 : dwell_q + DW'(1);
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
    col_d     = ~(COL_W'(1) << col_idx_d);

    n_low   = '0;
    row_hit = '0;
    for (int r = 0; r < ROW_W; r++) begin
      if (!sync2_q[r]) begin
        n_low   = n_low + 3'd1;
        row_hit = 2'(r);
      end
    end

    // A second low anywhere in the scan, or two in one column, poisons the scan.
    sample_acc = acc_q;
    if (n_low == 3'd1 && !acc_q.valid && !acc_q.multi) begin
      sample_acc.valid = 1'b1;
      sample_acc.code  = KEY_MAP[col_idx_q][row_hit];
    end else if (n_low != 3'd0) begin
      sample_acc.multi = 1'b1;
    end

    scan_res = NONE;
    if (sample_acc.valid && !sample_acc.multi) begin
      scan_res.valid = 1'b1;
      scan_res.code  = sample_acc.code;
    end

    acc_d = acc_q;
    if (sample)
      acc_d = scan_end ? NONE : sample_acc;
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .scan_end_i (scan_end),
    .result_i   (scan_res),
    .state_o    (db_state),
    .change_o   (db_change),
    .last_key_o (db_last_key)
  );

  assign col       = col_q;
  assign DispVal   = db_last_key;
  assign key_valid = db_change && db_state.valid;
  assign key_down  = db_state.valid;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_SCANS=3.
// Keys are changed on scan boundaries; expected key_valid pulses go into a scoreboard.
module tb_keypad_scanner;

  localparam int SCAN  = 4;
  localparam int DEB   = 3;
  localparam int SCANP = 4 * SCAN;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] DispVal;
  logic       key_valid;
  logic       key_down;

  logic [15:0] keys;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [15:0] keys;
    int          scans;
    bit          pulse;
    logic [3:0]  disp;
    logic        down;
  } step_t;

  typedef struct {
    logic [3:0] disp;
    int         at_cyc;
  } exp_t;

  step_t steps[$];
  exp_t  sb[$];

  keypad_scanner #(
    .SCAN_CYCLES   (SCAN),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .DispVal   (DispVal),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Matrix model: row r reads low when a pressed key sits on a driven-low column.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4 + r] && !col[c]) row[r] = 1'b0;
  end

  function automatic logic [15:0] k(input int c, input int r);
    k = 16'h0001 << (c*4 + r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b0 && key_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=key_valid %b DispVal %0h required=no pulse (cyc %0d)",
                 key_valid, DispVal, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_disp", {28'h0, DispVal}, {28'h0, e.disp});
        chk("pulse_cycle", cyc, e.at_cyc);
      end
    end
  end

  initial begin
    int s0;
    logic [3:0] exp_col;
    reset = 1'b1;
    keys  = '0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_col", {28'h0, col}, 32'hE);
    chk("rst_disp", {28'h0, DispVal}, 32'hF);
    chk("rst_kv", {31'h0, key_valid}, 32'h0);
    chk("rst_kd", {31'h0, key_down}, 32'h0);
    reset = 1'b0;

    for (int i = 1; i <= SCANP; i++) begin
      @(posedge clock);
      @(negedge clock);
      exp_col = ~(4'b0001 << ((i / SCAN) % 4));
      if (i % SCAN == 0) chk($sformatf("col_walk_%0d", i), {28'h0, col}, {28'h0, exp_col});
    end

    // Bounce on '8', then '1'+'2', '1' alone, '5', '4' -> 'A', releases.
    for (int i = 0; i < 8; i++)
      steps.push_back('{keys: (i % 2 == 0) ? k(1, 2) : 16'h0, scans: 1, pulse: 0, disp: 4'hF, down: 1'b0});
    steps.push_back('{keys: k(0, 0) | k(1, 0), scans: 4, pulse: 0, disp: 4'hF, down: 1'b0});
    steps.push_back('{keys: k(0, 0), scans: 4, pulse: 1, disp: 4'h1, down: 1'b1});
    steps.push_back('{keys: 16'h0, scans: 4, pulse: 0, disp: 4'h1, down: 1'b0});
    steps.push_back('{keys: k(1, 1), scans: 6, pulse: 1, disp: 4'h5, down: 1'b1});
    steps.push_back('{keys: 16'h0, scans: 4, pulse: 0, disp: 4'h5, down: 1'b0});
    steps.push_back('{keys: k(0, 1), scans: 4, pulse: 1, disp: 4'h4, down: 1'b1});
    steps.push_back('{keys: k(3, 0), scans: 4, pulse: 1, disp: 4'hA, down: 1'b1});
    steps.push_back('{keys: 16'h0, scans: 4, pulse: 0, disp: 4'hA, down: 1'b0});
    steps.push_back('{keys: k(0, 2), scans: 2, pulse: 0, disp: 4'hA, down: 1'b0});

    for (int i = 0; i < steps.size(); i++) begin
      keys = steps[i].keys;
      s0   = cyc;
      if (steps[i].pulse) sb.push_back('{disp: steps[i].disp, at_cyc: s0 + DEB * SCANP});
      repeat (steps[i].scans * SCANP) @(posedge clock);
      @(negedge clock);
      #1;
      chk($sformatf("step%0d_disp", i), {28'h0, DispVal}, {28'h0, steps[i].disp});
      chk($sformatf("step%0d_down", i), {31'h0, key_down}, {31'h0, steps[i].down});
      chk($sformatf("step%0d_pending", i), sb.size(), 0);
    end

    // '7' held across a one-cycle reset: debounce history must restart.
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("mid_rst_col", {28'h0, col}, 32'hE);
    chk("mid_rst_disp", {28'h0, DispVal}, 32'hF);
    chk("mid_rst_kv", {31'h0, key_valid}, 32'h0);
    chk("mid_rst_kd", {31'h0, key_down}, 32'h0);
    reset = 1'b0;
    s0 = cyc;
    sb.push_back('{disp: 4'h7, at_cyc: s0 + DEB * SCANP});
    repeat (2 * SCANP) @(posedge clock);
    @(negedge clock);
    #1;
    chk("mid_rst_early_kd", {31'h0, key_down}, 32'h0);
    repeat (2 * SCANP) @(posedge clock);
    @(negedge clock);
    #1;
    chk("mid_rst_disp7", {28'h0, DispVal}, 32'h7);
    chk("mid_rst_kd7", {31'h0, key_down}, 32'h1);
    chk("mid_rst_pending", sb.size(), 0);

    keys = '0;
    repeat (SCANP) @(posedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
